// File: rtl/conv1_pkg.sv
// conv1_pkg: constants, section tags, FSM states and address helpers shared by
// the conv1 load path (this transmitter and the conv1 block).
package conv1_pkg;

   localparam int unsigned DATA_WIDTH = 16;
   localparam int unsigned ADDR_WIDTH = 12;

   localparam int unsigned N_IMG   = 784;
   localparam int unsigned N_WGT   = 50;
   localparam int unsigned N_BIAS  = 2;
   localparam int unsigned N_TOTAL = N_IMG + N_WGT + N_BIAS;

   localparam int unsigned IMG_BASE  = 0;
   localparam int unsigned WGT_BASE  = 784;
   localparam int unsigned BIAS_BASE = 834;

   localparam int unsigned CNT_W = 10;

   typedef logic [CNT_W-1:0] cnt_t;

   typedef enum logic [1:0] {
      SEC_IMG  = 2'd0,
      SEC_WGT  = 2'd1,
      SEC_BIAS = 2'd2
   } sec_t;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_KICK,
      ST_READ,
      ST_DRAIN,
      ST_WAIT_FIN
   } state_t;

   // One read-pipe stage: beat qualifier plus the section it belongs to
   typedef struct packed {
      logic valid;
      sec_t sec;
   } rd_tag_t;

   // Section of the idx-th word in transfer order
   function automatic sec_t sec_of(input cnt_t idx);
      sec_t sec;
      if (idx < CNT_W'(N_IMG))
         sec = SEC_IMG;
      else if (idx < CNT_W'(N_IMG + N_WGT))
         sec = SEC_WGT;
      else
         sec = SEC_BIAS;
      return sec;
   endfunction

   // Memory address of the idx-th word in transfer order
   function automatic logic [ADDR_WIDTH-1:0] addr_of(input cnt_t idx);
      logic [ADDR_WIDTH-1:0] addr;
      case (sec_of(idx))
         SEC_IMG: addr = ADDR_WIDTH'(IMG_BASE) + ADDR_WIDTH'(idx);
         SEC_WGT: addr = ADDR_WIDTH'(WGT_BASE) + ADDR_WIDTH'(idx - CNT_W'(N_IMG));
         default: addr = ADDR_WIDTH'(BIAS_BASE) + ADDR_WIDTH'(idx - CNT_W'(N_IMG + N_WGT));
      endcase
      return addr;
   endfunction

endpackage

// File: rtl/conv1_rd_pipe.sv
// conv1_rd_pipe: 2-stage valid+tag pipe. Stage 1 tracks a read issued last
// cycle; stage 2 registers mem read data onto the bus of that read's section.
// Ports:
//   clk, reset_n        clock, async active-low reset
//   rd_issue, rd_sec    read issued this cycle and its section tag
//   rdata               memory read data (valid one cycle after the read)
//   data_valid          beat strobe, two cycles after the read
//   image_data / weight_data / bias_data
//                       section buses; only the tagged one is non-zero
module conv1_rd_pipe
   import conv1_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         rd_issue,
   input  sec_t                         rd_sec,
   input  logic        [DATA_WIDTH-1:0] rdata,
   output logic                         data_valid,
   output logic signed [DATA_WIDTH-1:0] image_data,
   output logic signed [DATA_WIDTH-1:0] weight_data,
   output logic signed [DATA_WIDTH-1:0] bias_data
);

   rd_tag_t s1;

   // Tag travels with the data so section switches need no bubble
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         s1          <= '0;
         data_valid  <= 1'b0;
         image_data  <= '0;
         weight_data <= '0;
         bias_data   <= '0;
      end else begin
         s1.valid    <= rd_issue;
         s1.sec      <= rd_sec;
         data_valid  <= s1.valid;
         image_data  <= (s1.valid && s1.sec == SEC_IMG)  ? $signed(rdata) : '0;
         weight_data <= (s1.valid && s1.sec == SEC_WGT)  ? $signed(rdata) : '0;
         bias_data   <= (s1.valid && s1.sec == SEC_BIAS) ? $signed(rdata) : '0;
      end
   end

endmodule

// File: rtl/conv1_stream_tx.sv
// conv1_stream_tx: on start, kicks conv1, streams 784 image words, 50 weights
// and 2 biases from the shared memory as 836 beats, then waits for conv1 to
// finish and pulses done.
// Ports:
//   clk, reset_n              clock, async active-low reset
//   start                     transfer request (sampled in IDLE only)
//   mem_ready                 arbiter grant; reads issue only while high
//   mem_rd_en, mem_addr       read strobe and address (same-cycle on grant)
//   mem_rdata                 read data, one cycle after mem_rd_en
//   start_conv1               one-cycle kick to conv1
//   data_valid                beat strobe to conv1
//   partial_image_in / partial_weights_in / partial_biases_in
//                             section data buses (inactive ones are 0)
//   finish_conv1              completion pulse from conv1
//   busy                      high from KICK through WAIT_FIN
//   done                      one-cycle pulse after finish_conv1
module conv1_stream_tx
   import conv1_pkg::*;
(
   input  logic                         clk,
   input  logic                         reset_n,
   input  logic                         start,
   input  logic                         mem_ready,
   output logic                         mem_rd_en,
   output logic        [ADDR_WIDTH-1:0] mem_addr,
   input  logic        [DATA_WIDTH-1:0] mem_rdata,
   output logic                         start_conv1,
   output logic                         data_valid,
   output logic signed [DATA_WIDTH-1:0] partial_image_in,
   output logic signed [DATA_WIDTH-1:0] partial_weights_in,
   output logic signed [DATA_WIDTH-1:0] partial_biases_in,
   input  logic                         finish_conv1,
   output logic                         busy,
   output logic                         done
);

   state_t state;
   state_t state_next;
   cnt_t   rd_cnt;
   cnt_t   tx_cnt;
   logic   rd_issue;
   sec_t   rd_sec;

   // State register
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         state <= ST_IDLE;
      else
         state <= state_next;
   end

   // Next state and read issue; reads depend on the grant in the same cycle
   always_comb begin
      state_next = state;
      rd_issue   = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start)
               state_next = ST_KICK;
         end
         ST_KICK: begin
            rd_issue   = mem_ready;
            state_next = ST_READ;
         end
         ST_READ: begin
            rd_issue = mem_ready;
            if (mem_ready && rd_cnt == CNT_W'(N_TOTAL - 1))
               state_next = ST_DRAIN;
         end
         ST_DRAIN: begin
            if (tx_cnt == CNT_W'(N_TOTAL))
               state_next = ST_WAIT_FIN;
         end
         ST_WAIT_FIN: begin
            if (finish_conv1)
               state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   assign rd_sec    = sec_of(rd_cnt);
   assign mem_rd_en = rd_issue;
   assign mem_addr  = rd_issue ? addr_of(rd_cnt) : '0;

   // Issue-side and emit-side counters, cleared while idle
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rd_cnt <= '0;
         tx_cnt <= '0;
      end else if (state == ST_IDLE) begin
         rd_cnt <= '0;
         tx_cnt <= '0;
      end else begin
         if (rd_issue)
            rd_cnt <= rd_cnt + CNT_W'(1);
         if (data_valid)
            tx_cnt <= tx_cnt + CNT_W'(1);
      end
   end

   // Control outputs registered from the next state so they align with it
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         start_conv1 <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
      end else begin
         start_conv1 <= (state_next == ST_KICK);
         busy        <= (state_next != ST_IDLE);
         done        <= (state == ST_WAIT_FIN) && finish_conv1;
      end
   end

   conv1_rd_pipe u_rd_pipe (
      .clk         (clk),
      .reset_n     (reset_n),
      .rd_issue    (rd_issue),
      .rd_sec      (rd_sec),
      .rdata       (mem_rdata),
      .data_valid  (data_valid),
      .image_data  (partial_image_in),
      .weight_data (partial_weights_in),
      .bias_data   (partial_biases_in)
   );

endmodule

// File: tb/tb_conv1_stream_tx.sv
// Bench for conv1_stream_tx: memory model (word = {key, address}), a small
// conv1 load model, and a scoreboard of expected beats built from issue order.
module tb_conv1_stream_tx;

   localparam int N_IMG  = 784;
   localparam int N_WGT  = 50;
   localparam int N_TOT  = 836;
   localparam int IMG_B  = 0;
   localparam int WGT_B  = 784;
   localparam int BIAS_B = 834;

   typedef struct packed {
      logic [15:0] img;
      logic [15:0] wgt;
      logic [15:0] bias;
      logic [31:0] cyc;
   } beat_t;

   logic               clk = 1'b0;
   logic               reset_n = 1'b1;
   logic               start = 1'b0;
   logic               mem_ready = 1'b1;
   logic               mem_rd_en;
   logic [11:0]        mem_addr;
   logic [15:0]        mem_rdata;
   logic               start_conv1;
   logic               data_valid;
   logic signed [15:0] partial_image_in;
   logic signed [15:0] partial_weights_in;
   logic signed [15:0] partial_biases_in;
   logic               finish_conv1;
   logic               finish_tb = 1'b0;
   logic               finish_model = 1'b0;
   logic               busy;
   logic               done;

   logic [3:0] key = 4'h0;
   bit         toggle_ready = 1'b0;
   bit         model_en = 1'b0;
   int         errors = 0;
   int         checks = 0;
   int         cyc = 0;

   beat_t exp_q[$];
   beat_t obs_q[$];
   int    n_iss, beats, bad_issue, sc_count, sc_cyc, first_beat, last_beat;
   int    done_count, done_cyc, busy_first, busy_fall;
   logic  prev_busy;

   int m_st, m_ld, m_img, m_wgt, m_bias, m_outside, m_wait, m_fin_cyc;

   conv1_stream_tx dut (
      .clk                (clk),
      .reset_n            (reset_n),
      .start              (start),
      .mem_ready          (mem_ready),
      .mem_rd_en          (mem_rd_en),
      .mem_addr           (mem_addr),
      .mem_rdata          (mem_rdata),
      .start_conv1        (start_conv1),
      .data_valid         (data_valid),
      .partial_image_in   (partial_image_in),
      .partial_weights_in (partial_weights_in),
      .partial_biases_in  (partial_biases_in),
      .finish_conv1       (finish_conv1),
      .busy               (busy),
      .done               (done)
   );

   assign finish_conv1 = finish_tb | finish_model;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Memory: one-cycle read latency, garbage when not read
   always @(posedge clk) mem_rdata <= mem_rd_en ? {key, mem_addr} : 16'($urandom);

   // conv1 load model: LOAD starts the cycle after it sees start_conv1
   always @(negedge clk) begin
      if (!reset_n || !model_en) begin
         m_st <= 0; m_ld <= 0; m_img <= 0; m_wgt <= 0; m_bias <= 0;
         m_outside <= 0; m_wait <= 0; finish_model <= 1'b0;
      end else begin
         finish_model <= 1'b0;
         if (data_valid && m_st != 1) m_outside <= m_outside + 1;
         case (m_st)
            0: if (start_conv1) m_st <= 1;
            1: if (data_valid) begin
                  m_ld <= m_ld + 1;
                  if (partial_image_in != 0)        m_img  <= m_img + 1;
                  else if (partial_weights_in != 0) m_wgt  <= m_wgt + 1;
                  else if (partial_biases_in != 0)  m_bias <= m_bias + 1;
                  if (m_ld == N_TOT - 1) begin m_st <= 2; m_wait <= 20; end
               end
            default: if (m_wait == 0) begin
                  finish_model <= 1'b1; m_st <= 0; m_fin_cyc <= cyc;
               end else m_wait <= m_wait - 1;
         endcase
      end
   end

   function automatic beat_t exp_beat(input int n, input int c);
      beat_t e;
      int a;
      logic [15:0] w;
      a = (n < N_IMG) ? IMG_B + n : (n < N_IMG + N_WGT) ? WGT_B + n - N_IMG : BIAS_B + n - N_IMG - N_WGT;
      w = {key, 12'(a)};
      e = '0;
      if (n < N_IMG) e.img = w;
      else if (n < N_IMG + N_WGT) e.wgt = w;
      else e.bias = w;
      e.cyc = 32'(c);
      return e;
   endfunction

   function automatic logic [64:0] all_outs();
      return {mem_rd_en, mem_addr, start_conv1, data_valid, partial_image_in,
              partial_weights_in, partial_biases_in, busy, done};
   endfunction

   task automatic clear_sb();
      exp_q.delete(); obs_q.delete();
      n_iss = 0; beats = 0; bad_issue = 0; sc_count = 0; sc_cyc = -1;
      first_beat = -1; last_beat = -1; done_count = 0; done_cyc = -1;
      busy_first = -1; busy_fall = -1; prev_busy = busy;
   endtask

   // Sample the current cycle at negedge, then advance to just after posedge
   task automatic step();
      beat_t b;
      @(negedge clk);
      if (mem_rd_en === 1'b1) begin
         if (mem_ready !== 1'b1) bad_issue++;
         exp_q.push_back(exp_beat(n_iss, cyc + 2));
         n_iss++;
      end
      if (data_valid === 1'b1) begin
         b = {partial_image_in, partial_weights_in, partial_biases_in, 32'(cyc)};
         obs_q.push_back(b);
         if (beats == 0) first_beat = cyc;
         last_beat = cyc;
         beats++;
      end
      if (start_conv1 === 1'b1) begin sc_count++; sc_cyc = cyc; end
      if (done === 1'b1) begin done_count++; done_cyc = cyc; end
      if (busy === 1'b1 && busy_first < 0) busy_first = cyc;
      if (prev_busy === 1'b1 && busy === 1'b0) busy_fall = cyc;
      prev_busy = busy;
      @(posedge clk); #1;
      if (toggle_ready) mem_ready = ~mem_ready;
   endtask

   task automatic pulse_finish();
      finish_tb = 1'b1; step(); finish_tb = 1'b0;
   endtask

   task automatic run_until_beats(input int target, input int budget);
      int n = 0;
      while (beats < target && n < budget) begin step(); n++; end
   endtask

   task automatic test_reset();
      #2 reset_n = 1'b0;
      #1 checks++;
      if (all_outs() !== 65'd0) begin errors++; $display("FAIL reset_outs: got %h expected 0", all_outs()); end
      repeat (2) @(posedge clk);
      #1 reset_n = 1'b1;
      clear_sb();
      repeat (4) step();
      checks++;
      if (beats != 0 || sc_count != 0 || busy_first != -1 || n_iss != 0) begin
         errors++; $display("FAIL idle_quiet: beats=%0d kicks=%0d busy_at=%0d reads=%0d expected all none", beats, sc_count, busy_first, n_iss);
      end
      checks++;
      if (all_outs() !== 65'd0) begin errors++; $display("FAIL idle_outs: got %h expected 0", all_outs()); end
   endtask

   task automatic test_full_stream();
      int c0;
      beat_t o, e;
      clear_sb(); key = 4'h0;
      start = 1'b1; c0 = cyc; step(); start = 1'b0;
      run_until_beats(N_TOT, 2000);
      repeat (10) step();
      checks++;
      if (sc_count != 1 || sc_cyc != c0 + 1) begin errors++; $display("FAIL kick: got %0d pulses at %0d expected 1 at %0d", sc_count, sc_cyc, c0 + 1); end
      checks++;
      if (busy_first != c0 + 1) begin errors++; $display("FAIL busy_rise: got %0d expected %0d", busy_first, c0 + 1); end
      checks++;
      if (first_beat != c0 + 3 || last_beat != c0 + 838) begin
         errors++; $display("FAIL beat_window: got %0d..%0d expected %0d..%0d", first_beat, last_beat, c0 + 3, c0 + 838);
      end
      checks++;
      if (beats != N_TOT || n_iss != N_TOT || bad_issue != 0) begin
         errors++; $display("FAIL full_count: got beats=%0d reads=%0d ungranted=%0d expected %0d/%0d/0", beats, n_iss, bad_issue, N_TOT, N_TOT);
      end
      for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL full_beat %0d: got %h/%h/%h@%0d expected %h/%h/%h@%0d", k, o.img, o.wgt, o.bias, o.cyc, e.img, e.wgt, e.bias, e.cyc); end
      end
      checks++;
      if (done_count != 0 || busy !== 1'b1) begin errors++; $display("FAIL wait_fin: got done=%0d busy=%b expected 0/1", done_count, busy); end
   endtask

   task automatic test_done_pulse();
      int f, n;
      n = 0;
      while (cyc < last_beat + 50 && n < 200) begin step(); n++; end
      f = cyc; pulse_finish();
      repeat (4) step();
      checks++;
      if (done_count != 1 || done_cyc != f + 1) begin errors++; $display("FAIL done_pulse: got %0d pulses at %0d expected 1 at %0d", done_count, done_cyc, f + 1); end
      checks++;
      if (busy_fall != f + 1) begin errors++; $display("FAIL busy_fall: got %0d expected %0d", busy_fall, f + 1); end
      checks++;
      if (beats != N_TOT) begin errors++; $display("FAIL after_done_beats: got %0d expected %0d", beats, N_TOT); end
   endtask

   task automatic test_ready_toggle();
      int f;
      beat_t o, e;
      clear_sb(); key = 4'hB; toggle_ready = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      run_until_beats(N_TOT, 4000);
      toggle_ready = 1'b0; mem_ready = 1'b1;
      repeat (10) step();
      checks++;
      if (beats != N_TOT || n_iss != N_TOT || bad_issue != 0) begin
         errors++; $display("FAIL toggle_count: got beats=%0d reads=%0d ungranted=%0d expected %0d/%0d/0", beats, n_iss, bad_issue, N_TOT, N_TOT);
      end
      for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL toggle_beat %0d: got %h/%h/%h@%0d expected %h/%h/%h@%0d", k, o.img, o.wgt, o.bias, o.cyc, e.img, e.wgt, e.bias, e.cyc); end
      end
      f = cyc; pulse_finish(); repeat (2) step();
      checks++;
      if (done_count != 1 || done_cyc != f + 1) begin errors++; $display("FAIL toggle_done: got %0d at %0d expected 1 at %0d", done_count, done_cyc, f + 1); end
   endtask

   task automatic test_ignored_inputs();
      int f;
      beat_t o, e;
      clear_sb(); key = 4'h5;
      start = 1'b1; step(); start = 1'b0;
      run_until_beats(100, 500);
      start = 1'b1; finish_tb = 1'b1; step(); start = 1'b0; finish_tb = 1'b0;
      run_until_beats(N_TOT, 2000);
      repeat (10) step();
      checks++;
      if (sc_count != 1 || done_count != 0 || busy !== 1'b1) begin
         errors++; $display("FAIL ignored: got kicks=%0d done=%0d busy=%b expected 1/0/1", sc_count, done_count, busy);
      end
      checks++;
      if (beats != N_TOT || n_iss != N_TOT) begin errors++; $display("FAIL ignored_count: got beats=%0d reads=%0d expected %0d", beats, n_iss, N_TOT); end
      for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL ignored_beat %0d: got %h/%h/%h@%0d expected %h/%h/%h@%0d", k, o.img, o.wgt, o.bias, o.cyc, e.img, e.wgt, e.bias, e.cyc); end
      end
      f = cyc; pulse_finish(); repeat (2) step();
      checks++;
      if (done_count != 1 || done_cyc != f + 1) begin errors++; $display("FAIL ignored_done: got %0d at %0d expected 1 at %0d", done_count, done_cyc, f + 1); end
   endtask

   task automatic test_reset_mid();
      int c0, f;
      beat_t o, e;
      clear_sb(); key = 4'h3;
      start = 1'b1; step(); start = 1'b0;
      run_until_beats(400, 1000);
      #2 reset_n = 1'b0;
      #1 checks++;
      if (all_outs() !== 65'd0) begin errors++; $display("FAIL mid_reset_outs: got %h expected 0", all_outs()); end
      step(); step();
      reset_n = 1'b1;
      clear_sb();
      start = 1'b1; c0 = cyc; step(); start = 1'b0;
      run_until_beats(N_TOT, 2000);
      repeat (10) step();
      checks++;
      if (beats != N_TOT || first_beat != c0 + 3 || sc_count != 1) begin
         errors++; $display("FAIL restart: got beats=%0d first=%0d kicks=%0d expected %0d/%0d/1", beats, first_beat, sc_count, N_TOT, c0 + 3);
      end
      for (int k = 0; obs_q.size() > 0 && exp_q.size() > 0; k++) begin
         o = obs_q.pop_front(); e = exp_q.pop_front(); checks++;
         if (o !== e) begin errors++; $display("FAIL restart_beat %0d: got %h/%h/%h@%0d expected %h/%h/%h@%0d", k, o.img, o.wgt, o.bias, o.cyc, e.img, e.wgt, e.bias, e.cyc); end
      end
      f = cyc; pulse_finish(); repeat (2) step();
      checks++;
      if (done_count != 1 || done_cyc != f + 1) begin errors++; $display("FAIL restart_done: got %0d at %0d expected 1 at %0d", done_count, done_cyc, f + 1); end
   endtask

   task automatic test_conv1_model();
      int n;
      clear_sb(); key = 4'h9; model_en = 1'b1;
      start = 1'b1; step(); start = 1'b0;
      n = 0;
      while (done_count == 0 && n < 3000) begin step(); n++; end
      repeat (3) step();
      checks++;
      if (m_img != 784 || m_wgt != 50 || m_bias != 2 || m_outside != 0) begin
         errors++; $display("FAIL model_load: got img=%0d wgt=%0d bias=%0d outside=%0d expected 784/50/2/0", m_img, m_wgt, m_bias, m_outside);
      end
      checks++;
      if (done_count != 1 || done_cyc != m_fin_cyc + 1) begin
         errors++; $display("FAIL model_done: got %0d at %0d expected 1 at %0d", done_count, done_cyc, m_fin_cyc + 1);
      end
      checks++;
      if (beats != N_TOT || busy !== 1'b0) begin errors++; $display("FAIL model_end: got beats=%0d busy=%b expected %0d/0", beats, busy, N_TOT); end
      model_en = 1'b0;
   endtask

   initial begin
      test_reset();
      test_full_stream();
      test_done_pulse();
      test_ready_toggle();
      test_ignored_inputs();
      test_reset_mid();
      test_conv1_model();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
